// File: rtl/matriz_max7219_driver.sv
// matriz_max7219_driver: sends the MAX7219 init words, then keeps refreshing the 8 digit rows over DIN/SCLK/LOAD
module matriz_max7219_driver #(
    parameter int         DATAWIDTH  = 8,
    parameter int         CLKDIV     = 4,
    parameter logic [3:0] INTENSITY  = 4'h8,
    parameter logic [2:0] SCAN_LIMIT = 3'd7
) (
    input  logic                 MatrizDriver_CLOCK_50,
    input  logic                 MatrizDriver_RESET_InHigh,
    input  logic [DATAWIDTH-1:0] MatrizDriver_Fila1_In,
    input  logic [DATAWIDTH-1:0] MatrizDriver_Fila2_In,
    input  logic [DATAWIDTH-1:0] MatrizDriver_Fila3_In,
    input  logic [DATAWIDTH-1:0] MatrizDriver_Fila4_In,
    input  logic [DATAWIDTH-1:0] MatrizDriver_Fila5_In,
    input  logic [DATAWIDTH-1:0] MatrizDriver_Fila6_In,
    input  logic [DATAWIDTH-1:0] MatrizDriver_Fila7_In,
    input  logic [DATAWIDTH-1:0] MatrizDriver_Fila8_In,
    output logic                 MatrizDriver_DIN_Out,
    output logic                 MatrizDriver_SCLK_Out,
    output logic                 MatrizDriver_LOAD_Out,
    output logic                 MatrizDriver_Ready_Out,
    output logic                 MatrizDriver_FrameDone_Out
);
    localparam int WW = 8 + DATAWIDTH;
    localparam int BW = $clog2(WW);
    localparam int PW = $clog2(2 * CLKDIV + 1);
    localparam logic [PW-1:0] PH_LAST  = PW'(2 * CLKDIV - 1);
    localparam logic [PW-1:0] PH_HALF  = PW'(CLKDIV);
    localparam logic [PW-1:0] PH_LATCH = PW'(CLKDIV - 1);

    typedef enum logic [1:0] {START, LOADWORD, SHIFT, LATCH} state_t;

    logic clk, rst;
    state_t state, state_n;
    logic [3:0] idx, idx_n;
    logic [BW-1:0] bit_idx, bit_n;
    logic [PW-1:0] phase, phase_n;
    logic [WW-1:0] word, word_n, word_b;
    logic ready_n, done_n;
    logic [2:0] slot;
    logic [DATAWIDTH-1:0] row;
    logic [DATAWIDTH-1:0] fila [8];
    logic [DATAWIDTH-1:0] shadow [8];

    assign clk = MatrizDriver_CLOCK_50;
    assign rst = MatrizDriver_RESET_InHigh;
    assign fila = '{MatrizDriver_Fila1_In, MatrizDriver_Fila2_In, MatrizDriver_Fila3_In, MatrizDriver_Fila4_In,
                    MatrizDriver_Fila5_In, MatrizDriver_Fila6_In, MatrizDriver_Fila7_In, MatrizDriver_Fila8_In};

    // row 1 bypasses the shadow because it is captured on the same edge its word is built
    assign slot = 3'(idx - 4'd5);
    assign row = idx == 4'd5 ? fila[0] : shadow[slot];
    assign word_b = idx == 4'd0 ? {8'h0F, DATAWIDTH'(0)} :
                    idx == 4'd1 ? {8'h09, DATAWIDTH'(0)} :
                    idx == 4'd2 ? {8'h0A, DATAWIDTH'(INTENSITY)} :
                    idx == 4'd3 ? {8'h0B, DATAWIDTH'(SCAN_LIMIT)} :
                    idx == 4'd4 ? {8'h0C, DATAWIDTH'(1)} :
                    {4'h0, idx - 4'd4, row};

    // next-state, counters and flags for the word sequencer
    always_comb begin
        state_n = state;
        idx_n = idx;
        bit_n = bit_idx;
        phase_n = phase;
        word_n = word;
        ready_n = MatrizDriver_Ready_Out;
        done_n = 1'b0;
        case (state)
            START: state_n = LOADWORD;
            LOADWORD: begin
                state_n = SHIFT;
                word_n = word_b;
                bit_n = BW'(WW - 1);
                phase_n = '0;
            end
            SHIFT: begin
                phase_n = phase == PH_LAST ? '0 : phase + 1'b1;
                if (phase == PH_LAST && bit_idx == '0) state_n = LATCH;
                if (phase == PH_LAST && bit_idx != '0) bit_n = bit_idx - 1'b1;
            end
            LATCH: begin
                phase_n = phase == PH_LATCH ? '0 : phase + 1'b1;
                if (phase == PH_LATCH) begin
                    state_n = LOADWORD;
                    idx_n = idx == 4'd12 ? 4'd5 : idx + 4'd1;
                    ready_n = MatrizDriver_Ready_Out | (idx == 4'd4);
                    done_n = idx == 4'd12;
                end
            end
            default: state_n = START;
        endcase
    end

    // state register with glitch-free registered serial outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= START;
            idx <= '0;
            bit_idx <= '0;
            phase <= '0;
            word <= '0;
            MatrizDriver_Ready_Out <= 1'b0;
            MatrizDriver_FrameDone_Out <= 1'b0;
            MatrizDriver_DIN_Out <= 1'b0;
            MatrizDriver_SCLK_Out <= 1'b0;
            MatrizDriver_LOAD_Out <= 1'b1;
        end else begin
            state <= state_n;
            idx <= idx_n;
            bit_idx <= bit_n;
            phase <= phase_n;
            word <= word_n;
            MatrizDriver_Ready_Out <= ready_n;
            MatrizDriver_FrameDone_Out <= done_n;
            MatrizDriver_DIN_Out <= state_n == SHIFT && word_n[bit_n];
            MatrizDriver_SCLK_Out <= state_n == SHIFT && phase_n >= PH_HALF;
            MatrizDriver_LOAD_Out <= !(state_n == LOADWORD || state_n == SHIFT);
        end
    end

    // frame snapshot so a frame is never torn by mid-frame row changes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) shadow <= '{default: '0};
        else if (state == LOADWORD && idx == 4'd5) shadow <= fila;
    end
endmodule
